fir_ap_ctrl: RTL
================

Name: fir_ap_ctrl

Overview:
Block-level sequencer for the FIR core: owns the ap_ctrl/status, data_length and tap_num registers, and runs the IDLE→CLEAR→RUN→DONE flow.
- CLEAR zeroes the data-RAM shift window before each run.
- Counts AXI-Stream input/output handshakes and generates sm_tlast.
- Blocks coefficient (tap RAM) writes and length-register writes while a run is active.
- Sits between the AXI-Lite decoder and the FIR MAC engine, which keeps its own RAM ports and uses this block's clear signals during CLEAR.

Parameters:
pADDR_WIDTH, 12, AXI-Lite / RAM address width
pDATA_WIDTH, 32, register and data width
pMAX_TAP, 32, maximum tap count; tap_num writes above this saturate to pMAX_TAP

Ports:
axis_clk  in  1  clock, all logic on rising edge
axis_rst  in  1  synchronous active-high reset
cfg_wen  in  1  one-cycle register write strobe from AXI-Lite decoder
cfg_waddr  in  pADDR_WIDTH  write address
cfg_wdata  in  pDATA_WIDTH  write data
cfg_ren  in  1  one-cycle register read strobe
cfg_raddr  in  pADDR_WIDTH  read address
cfg_rdata  out  pDATA_WIDTH  read data, registered
cfg_rvalid  out  1  one-cycle pulse, cycle after cfg_ren
ss_hs  in  1  ss_tvalid & ss_tready seen by engine
sm_hs  in  1  sm_tvalid & sm_tready seen by engine
ss_allow  out  1  engine may raise ss_tready
eng_en  out  1  MAC engine enable
clr_we  out  1  data-RAM clear write enable (engine muxes to data_WE=4'hF, data_Di=0)
clr_addr  out  pADDR_WIDTH  data-RAM clear byte address
tap_lock  out  1  1 = tap RAM AXI-Lite writes must be dropped
sm_tlast  out  1  marks last output sample
tap_num  out  pDATA_WIDTH  current tap count to engine

Behaviour:
- Reset values: cfg_rdata=0, cfg_rvalid=0, ss_allow=0, eng_en=0, clr_we=0, clr_addr=0, tap_lock=0, sm_tlast=0, tap_num=0.
- Reset internal state: data_length=0, ap_done=0, ap_idle=1, in_cnt=0, out_cnt=0, state=IDLE.
- Reset mid-run: same result on the next edge; all counters cleared and length registers zeroed.
- Register map:
  - 0x00 ap_ctrl: bit0 ap_start (W, reads 0), bit1 ap_done (RO, clear-on-read), bit2 ap_idle (RO).
  - 0x10 data_length (RW).
  - 0x14 tap_num (RW).
  - Other addresses read 0; writes to them are ignored.
- Writes to 0x10/0x14 are accepted only in IDLE; otherwise dropped.
- Read of 0x00 while ap_done=1: returns bit1=1, and ap_done clears on that edge.
- If ap_done is set in the same cycle as a 0x00 read: the read returns 0 and ap_done stays 1.
- States:
  - IDLE: ap_idle=1, tap_lock=0. Write of 0x00 with bit0=1 → CLEAR next edge. On that edge: ap_idle←0, tap_lock←1, ap_done←0, counters←0.
  - CLEAR: clr_we=1 for tap_num cycles, clr_addr=0,4,8,…,4*(tap_num-1). Then → RUN if data_length>0, else → DONE. If tap_num=0, CLEAR lasts exactly 1 cycle with clr_we=0.
  - RUN: eng_en=1; ss_allow=1 while in_cnt<data_length.
    - in_cnt increments on ss_hs and out_cnt on sm_hs; ss_hs while ss_allow=0 is ignored.
    - sm_tlast=1 while out_cnt==data_length-1.
    - When sm_hs occurs with out_cnt==data_length-1 → DONE.
  - DONE (1 cycle): ap_done←1, ap_idle←1, eng_en←0, tap_lock←0, then → IDLE.
- ap_start written while not in IDLE is ignored. Start-to-first-ss_allow latency = tap_num+1 cycles.
- Counters are 32-bit with no wrap; data_length is treated as unsigned.

Test Plan:
- Reset then read 0x00 → cfg_rdata=0x4 one cycle after cfg_ren. Write 0x10=600 and read back → 600.
- tap_num=31, data_length=600, ap_start: clr_we high exactly 31 cycles, addr 0..120; ss_allow rises at cycle 32. Feed 600 ss_hs/sm_hs → sm_tlast only on output 599, then 0x00 reads 0x6, then a second read returns 0x4.
- During RUN: write 0x14=5 and 0x00=1 → tap_num stays 31, no restart, tap_lock=1 throughout.
- data_length=0, tap_num=0, start → CLEAR 1 cycle, DONE, ap_done=1 within 3 cycles, ss_allow never asserted.
- Write tap_num=40 → reads 32 (pMAX_TAP). Extra ss_hs after 600 inputs → in_cnt stays 600.
- Assert axis_rst at output 300 → next cycle eng_en=0, 0x00 reads 0x4, data_length reads 0; a fresh run then completes correctly.

Source files
------------

// File: rtl/fir_ap_ctrl.sv
// ---------------------------------------------------------------------------
// fir_ap_ctrl
// Block-level sequencer for the FIR core. Holds the ap_ctrl status bits, the
// data_length and tap_num configuration registers, and walks the
// IDLE -> CLEAR -> RUN -> DONE flow for one filtering run.
//
// Ports
//   axis_clk, axis_rst        : clock, synchronous active-high reset
//   cfg_wen/waddr/wdata       : one-cycle register write from the AXI-Lite decoder
//   cfg_ren/raddr             : one-cycle register read strobe
//   cfg_rdata/cfg_rvalid      : registered read data, valid the cycle after cfg_ren
//   ss_hs, sm_hs              : input / output stream handshakes seen by the engine
//   ss_allow                  : engine may accept input samples
//   eng_en                    : MAC engine enable
//   clr_we, clr_addr          : data-RAM zeroing write enable and byte address
//   tap_lock                  : tap RAM writes from AXI-Lite must be dropped
//   sm_tlast                  : current output sample is the last of the run
//   tap_num                   : active tap count to the engine
// ---------------------------------------------------------------------------
module fir_ap_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pMAX_TAP    = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cfg_wen,
  input  logic [pADDR_WIDTH-1:0] cfg_waddr,
  input  logic [pDATA_WIDTH-1:0] cfg_wdata,
  input  logic                   cfg_ren,
  input  logic [pADDR_WIDTH-1:0] cfg_raddr,
  output logic [pDATA_WIDTH-1:0] cfg_rdata,
  output logic                   cfg_rvalid,
  input  logic                   ss_hs,
  input  logic                   sm_hs,
  output logic                   ss_allow,
  output logic                   eng_en,
  output logic                   clr_we,
  output logic [pADDR_WIDTH-1:0] clr_addr,
  output logic                   tap_lock,
  output logic                   sm_tlast,
  output logic [pDATA_WIDTH-1:0] tap_num
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = pADDR_WIDTH'(8'h00);
  localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(8'h10);
  localparam logic [pADDR_WIDTH-1:0] ADDR_TAP  = pADDR_WIDTH'(8'h14);

  localparam logic [pDATA_WIDTH-1:0] D_ZERO = {pDATA_WIDTH{1'b0}};
  localparam logic [pDATA_WIDTH-1:0] D_ONE  = pDATA_WIDTH'(1'b1);
  localparam logic [pDATA_WIDTH-1:0] D_MAXT = pDATA_WIDTH'(pMAX_TAP);
  localparam logic [pADDR_WIDTH-1:0] A_ZERO = {pADDR_WIDTH{1'b0}};
  localparam logic [pADDR_WIDTH-1:0] A_STEP = pADDR_WIDTH'(3'd4);

  logic [1:0]             r_state;
  logic [pDATA_WIDTH-1:0] r_data_length;
  logic [pDATA_WIDTH-1:0] r_tap_num;
  logic                   r_ap_done;
  logic                   r_ap_idle;
  logic [pDATA_WIDTH-1:0] r_in_cnt;
  logic [pDATA_WIDTH-1:0] r_out_cnt;
  logic [pDATA_WIDTH-1:0] r_clr_cnt;
  logic [pADDR_WIDTH-1:0] r_clr_addr;
  logic                   r_clr_we;
  logic                   r_eng_en;
  logic                   r_ss_allow;
  logic                   r_sm_tlast;
  logic                   r_tap_lock;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic                   r_rvalid;

  logic                   w_idle;
  logic                   w_start;
  logic                   w_wr_len;
  logic                   w_wr_tap;
  logic [pDATA_WIDTH-1:0] w_tap_sat;
  logic                   w_ctrl_rd;
  logic                   w_in_hs;
  logic                   w_out_hs;
  logic [pDATA_WIDTH-1:0] w_in_cnt_nxt;
  logic [pDATA_WIDTH-1:0] w_out_cnt_nxt;
  logic [pDATA_WIDTH-1:0] w_len_m1;
  logic                   w_last_out;
  logic                   w_clr_last;

  assign cfg_rdata  = r_rdata;
  assign cfg_rvalid = r_rvalid;
  assign ss_allow   = r_ss_allow;
  assign eng_en     = r_eng_en;
  assign clr_we     = r_clr_we;
  assign clr_addr   = r_clr_addr;
  assign tap_lock   = r_tap_lock;
  assign sm_tlast   = r_sm_tlast;
  assign tap_num    = r_tap_num;

  // Register decode, handshake qualification and next-count values.
  always_comb begin
    w_idle    = (r_state == S_IDLE);
    w_start   = cfg_wen && (cfg_waddr == ADDR_CTRL) && cfg_wdata[0] && w_idle;
    w_wr_len  = cfg_wen && (cfg_waddr == ADDR_LEN) && w_idle;
    w_wr_tap  = cfg_wen && (cfg_waddr == ADDR_TAP) && w_idle;
    if (cfg_wdata > D_MAXT) begin
      w_tap_sat = D_MAXT;
    end else begin
      w_tap_sat = cfg_wdata;
    end
    w_ctrl_rd = cfg_ren && (cfg_raddr == ADDR_CTRL);
    // Input handshakes only count while the engine was told it may accept,
    // so in_cnt can never run past data_length.
    w_in_hs       = ss_hs && r_ss_allow && (r_state == S_RUN);
    w_out_hs      = sm_hs && (r_state == S_RUN);
    w_in_cnt_nxt  = r_in_cnt + pDATA_WIDTH'(w_in_hs);
    w_out_cnt_nxt = r_out_cnt + pDATA_WIDTH'(w_out_hs);
    w_len_m1      = r_data_length - D_ONE;
    w_last_out    = w_out_hs && (r_out_cnt == w_len_m1);
    // tap_num=0 still spends one CLEAR cycle, with no writes issued.
    w_clr_last    = (r_tap_num == D_ZERO) || ((r_clr_cnt + D_ONE) == r_tap_num);
  end

  // Configuration registers; writable only while idle.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_data_length <= D_ZERO;
      r_tap_num     <= D_ZERO;
    end else begin
      if (w_wr_len) begin
        r_data_length <= cfg_wdata;
      end else begin
        r_data_length <= r_data_length;
      end
      if (w_wr_tap) begin
        r_tap_num <= w_tap_sat;
      end else begin
        r_tap_num <= r_tap_num;
      end
    end
  end

  // Sequencer: state, counters, clear walk and engine-facing controls.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_state    <= S_IDLE;
      r_ap_idle  <= 1'b1;
      r_in_cnt   <= D_ZERO;
      r_out_cnt  <= D_ZERO;
      r_clr_cnt  <= D_ZERO;
      r_clr_addr <= A_ZERO;
      r_clr_we   <= 1'b0;
      r_eng_en   <= 1'b0;
      r_ss_allow <= 1'b0;
      r_sm_tlast <= 1'b0;
      r_tap_lock <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_CLEAR;
            r_ap_idle  <= 1'b0;
            r_tap_lock <= 1'b1;
            r_in_cnt   <= D_ZERO;
            r_out_cnt  <= D_ZERO;
            r_clr_cnt  <= D_ZERO;
            r_clr_addr <= A_ZERO;
            r_clr_we   <= (r_tap_num != D_ZERO);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (w_clr_last) begin
            r_clr_we <= 1'b0;
            if (r_data_length != D_ZERO) begin
              r_state    <= S_RUN;
              r_eng_en   <= 1'b1;
              r_ss_allow <= 1'b1;
              r_sm_tlast <= (r_data_length == D_ONE);
            end else begin
              r_state <= S_DONE;
            end
          end else begin
            r_clr_cnt  <= r_clr_cnt + D_ONE;
            r_clr_addr <= r_clr_addr + A_STEP;
          end
        end
        S_RUN: begin
          r_in_cnt  <= w_in_cnt_nxt;
          r_out_cnt <= w_out_cnt_nxt;
          if (w_last_out) begin
            r_state    <= S_DONE;
            r_eng_en   <= 1'b0;
            r_ss_allow <= 1'b0;
            r_sm_tlast <= 1'b0;
          end else begin
            r_ss_allow <= (w_in_cnt_nxt < r_data_length);
            r_sm_tlast <= (w_out_cnt_nxt == w_len_m1);
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_ap_idle  <= 1'b1;
          r_eng_en   <= 1'b0;
          r_tap_lock <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ap_done: set when leaving DONE, cleared by start or by a read that saw it.
  // A read racing the set edge returns the old 0 and leaves the bit set.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_ap_done <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_ap_done <= 1'b1;
    end else if (w_start) begin
      r_ap_done <= 1'b0;
    end else if (w_ctrl_rd && r_ap_done) begin
      r_ap_done <= 1'b0;
    end else begin
      r_ap_done <= r_ap_done;
    end
  end

  // Registered read port.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_rdata  <= D_ZERO;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= cfg_ren;
      if (cfg_ren) begin
        case (cfg_raddr)
          ADDR_CTRL: r_rdata <= pDATA_WIDTH'({r_ap_idle, r_ap_done, 1'b0});
          ADDR_LEN:  r_rdata <= r_data_length;
          ADDR_TAP:  r_rdata <= r_tap_num;
          default:   r_rdata <= D_ZERO;
        endcase
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

endmodule
